alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Parametrised, registered successor to the combinational ALU control decoder. It sits at the ID/EX boundary and registers the decoded ALU control word. It extends decode to SLT/SLTU, I-type arithmetic and the RV32M multiply/divide group. For multi-cycle M-extension ops it sequences a latency counter that stalls the pipeline until the result is due.

## Interface
- CTRL_W, 4: ALUCtrl width; must be ≥4; codes zero-extended.
- MUL_LAT, 3: cycles for MUL/MULH, ≥1.
- DIV_LAT, 32: cycles for DIV/DIVU/REM/REMU, ≥1.
- CNT_W, 6: counter width; must hold max(MUL_LAT, DIV_LAT)−1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- funct7  in  7  instruction funct7.
- funct3  in  3  instruction funct3.
- ALUOp  in  2  00 add, 01 sub, 10 R-type, 11 I-type arithmetic.
- valid_i  in  1  decode inputs valid this cycle.
- flush_i  in  1  abort current op; synchronous.
- ALUCtrl  out  CTRL_W  registered control code.
- ctrl_valid_o  out  1  ALUCtrl belongs to a live op.
- illegal_o  out  1  registered; accepted encoding undefined.
- stall_o  out  1  combinational = (state==BUSY).
- done_o  out  1  one-cycle pulse; the EX result is due this cycle.

## Operation
- Codes: add 0, sub 1, and 2, or 3, xor 4, sll 5, sra 6, srl 7, slt 8, sltu 9, mul 10, mulh 11, div 12, divu 13, rem 14, remu 15.
- ALUOp 00 → add. ALUOp 01 → sub. funct fields are ignored for both.
- ALUOp 10, funct7=0000000:
  - funct3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and.
- ALUOp 10, funct7=0100000:
  - funct3 000 sub, 101 sra.
  - Any other funct3 is illegal.
- ALUOp 10, funct7=0000001:
  - funct3 000 mul, 001 mulh, 100 div, 101 divu, 110 rem, 111 remu.
  - funct3 010 and 011 are illegal.
- ALUOp 10, any other funct7 → illegal.
- ALUOp 11:
  - funct3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and.
  - For these funct3 values, funct7 is ignored.
  - funct3 001: funct7 must be 0000000 → sll, else illegal.
  - funct3 101: funct7 0000000 → srl, 0100000 → sra, else illegal.
- Illegal encodings register ALUCtrl=0 (add) with illegal_o=1. They are single-cycle.
- Acceptance: valid_i && !stall_o && !flush_i at a rising edge.
- States: IDLE, BUSY.
- IDLE, on accept:
  - Register ALUCtrl and illegal_o; set ctrl_valid_o=1.
  - LAT = MUL_LAT for mul/mulh, DIV_LAT for the div/rem group, 1 otherwise.
  - LAT=1: stay IDLE; done_o=1 next cycle.
  - LAT>1: go BUSY, cnt←LAT−1.
- IDLE, no accept: ctrl_valid_o←0, done_o←0. ALUCtrl holds its last value.
- BUSY: ALUCtrl and ctrl_valid_o hold; cnt decrements each edge.
  - When cnt==1: cnt←0, state←IDLE, done_o←1.
- While stall_o is high, valid_i is ignored; upstream holds the instruction.
- flush_i at an edge, from any state:
  - state←IDLE, cnt←0, ctrl_valid_o←0, done_o←0, illegal_o←0. ALUCtrl holds.
  - flush_i wins over a simultaneous accept.

## Timing
- Reset, asynchronous: ALUCtrl=0, ctrl_valid_o=0, illegal_o=0, done_o=0, state IDLE (stall_o=0), cnt=0.
- Accept at edge k:
  - ALUCtrl and ctrl_valid_o are valid from k+1.
  - stall_o is high for cycles k+1 … k+LAT−1.
  - done_o is high for exactly the cycle starting at k+LAT.
- Back-to-back: the done_o cycle is IDLE with stall_o=0, so a new op is accepted at that cycle's closing edge with no bubble.
- Single-cycle ops accept every cycle; ctrl_valid_o and done_o are continuously high.
- Flush during BUSY: stall_o drops the cycle after the flush edge. No done_o for the aborted op.
- Reset deasserting mid-BUSY: the block restarts in IDLE and no done_o is emitted.

## Test plan
- Reset then R-type add/sub: ALUOp=10, funct3=000, funct7=0100000 with valid_i → next cycle ALUCtrl=1, ctrl_valid_o=1, done_o=1, stall_o=0.
- I-type sweep: ALUOp=11 over every funct3 with funct7=0100000:
  - 101 → 6 (sra); 001 → illegal_o=1, ALUCtrl=0; 000 → 0 (add; funct7 ignored).
- MUL with MUL_LAT=3: accept at edge k → stall_o high for cycles k+1 and k+2 with ALUCtrl=10 held; done_o pulses at k+3. A queued add is accepted at k+3 and yields done_o at k+4.
- DIV with DIV_LAT=32: stall_o high for 31 cycles, done_o on the 32nd. Repeat with DIV_LAT=1: no stall, done_o at k+1.
- Flush at cycle 5 of a DIV: stall_o low next cycle, ctrl_valid_o=0, no done_o. valid_i asserted together with flush_i is not accepted.
- Assert rst_n low mid-BUSY → all outputs zero immediately, without waiting for a clock edge. After release, an accepted xor (funct3=100, funct7=0) → ALUCtrl=4 next cycle.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder for the ID/EX boundary, with a latency
// sequencer that stalls the pipeline while multi-cycle M-extension ops run.
module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic [1:0]        ALUOp,
    input  logic              valid_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ALUCtrl,
    output logic              ctrl_valid_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              done_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRA  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
    logic              ctrl_valid_q, ctrl_valid_d;
    logic              illegal_q, illegal_d;
    logic              done_q, done_d;

    logic [3:0]        dec_code;
    logic              dec_illegal;
    logic              dec_multi;
    logic [CNT_W-1:0]  dec_load;
    logic              accept;

    // Pure decode of the instruction fields; illegal encodings fall back to add.
    always_comb begin
        dec_code    = OP_ADD;
        dec_illegal = 1'b0;
        unique case (ALUOp)
            2'b00: dec_code = OP_ADD;
            2'b01: dec_code = OP_SUB;
            2'b10: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  dec_code = OP_ADD;
                            3'b001:  dec_code = OP_SLL;
                            3'b010:  dec_code = OP_SLT;
                            3'b011:  dec_code = OP_SLTU;
                            3'b100:  dec_code = OP_XOR;
                            3'b101:  dec_code = OP_SRL;
                            3'b110:  dec_code = OP_OR;
                            default: dec_code = OP_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)
                            dec_code = OP_SUB;
                        else if (funct3 == 3'b101)
                            dec_code = OP_SRA;
                        else
                            dec_illegal = 1'b1;
                    end
                    F7_MEXT: begin
                        case (funct3)
                            3'b000:  dec_code = OP_MUL;
                            3'b001:  dec_code = OP_MULH;
                            3'b100:  dec_code = OP_DIV;
                            3'b101:  dec_code = OP_DIVU;
                            3'b110:  dec_code = OP_REM;
                            3'b111:  dec_code = OP_REMU;
                            default: dec_illegal = 1'b1;
                        endcase
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                // Shift-immediates are the only I-type ops that look at funct7.
                case (funct3)
                    3'b000: dec_code = OP_ADD;
                    3'b010: dec_code = OP_SLT;
                    3'b011: dec_code = OP_SLTU;
                    3'b100: dec_code = OP_XOR;
                    3'b110: dec_code = OP_OR;
                    3'b111: dec_code = OP_AND;
                    3'b001: begin
                        if (funct7 == F7_BASE)
                            dec_code = OP_SLL;
                        else
                            dec_illegal = 1'b1;
                    end
                    default: begin
                        if (funct7 == F7_BASE)
                            dec_code = OP_SRL;
                        else if (funct7 == F7_ALT)
                            dec_code = OP_SRA;
                        else
                            dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_comb begin
        dec_multi = 1'b0;
        dec_load  = '0;
        if ((dec_code == OP_MUL || dec_code == OP_MULH) && MUL_LAT > 1) begin
            dec_multi = 1'b1;
            dec_load  = MUL_LOAD;
        end else if (dec_code >= OP_DIV && DIV_LAT > 1) begin
            dec_multi = 1'b1;
            dec_load  = DIV_LOAD;
        end
    end

    assign stall_o = (state_q == BUSY);
    assign accept  = valid_i && !stall_o && !flush_i;

    // Flush dominates; otherwise IDLE accepts new ops and BUSY counts down.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_ctrl_d   = alu_ctrl_q;
        ctrl_valid_d = ctrl_valid_q;
        illegal_d    = illegal_q;
        done_d       = 1'b0;
        if (flush_i) begin
            state_d      = IDLE;
            cnt_d        = '0;
            ctrl_valid_d = 1'b0;
            illegal_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_ctrl_d   = CTRL_W'(dec_code);
                        illegal_d    = dec_illegal;
                        ctrl_valid_d = 1'b1;
                        if (dec_multi) begin
                            state_d = BUSY;
                            cnt_d   = dec_load;
                        end else begin
                            done_d = 1'b1;
                        end
                    end else begin
                        ctrl_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_ctrl_q   <= '0;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            illegal_q    <= illegal_d;
            done_q       <= done_d;
        end
    end

    assign ALUCtrl      = alu_ctrl_q;
    assign ctrl_valid_o = ctrl_valid_q;
    assign illegal_o    = illegal_q;
    assign done_o       = done_q;

endmodule
